// File: rtl/bnn_frame_sched.sv
// bnn_frame_sched: binarises a raster pixel stream into a full frame for the BNN core,
// requests one score per class, and reduces the returned scores to a one-hot argmax.
//
// state | meaning
// IDLE  | single cycle after reset release
// LOAD  | accepting pixels, pix_ready high
// REQ   | core_req high for class core_cls, waiting for core_ack
// GAP   | one idle cycle between class requests
// DONE  | pred/pred_valid presented for one cycle
module bnn_frame_sched #(
    parameter int IMG_W   = 16,
    parameter int IMG_H   = 16,
    parameter int THRESH  = 128,
    parameter int N_OUT   = 10,
    parameter int SCORE_W = 10
) (
    input  logic                     clk,
    input  logic                     xrst,
    input  logic                     pix_valid,
    input  logic [7:0]               pix,
    output logic                     pix_ready,
    output logic [IMG_W*IMG_H-1:0]   core_img,
    output logic                     core_req,
    output logic [3:0]               core_cls,
    input  logic                     core_ack,
    input  logic [SCORE_W-1:0]       core_score,
    output logic [N_OUT-1:0]         pred,
    output logic                     pred_valid,
    output logic                     busy
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int CLS_W = 4;
    localparam logic [7:0]       THR8     = 8'(THRESH);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);
    localparam logic [CLS_W-1:0] LAST_CLS = CLS_W'(N_OUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_GAP,
        S_DONE
    } state_t;

    state_t                     state, state_d;
    logic [CNT_W-1:0]           pix_cnt, pix_cnt_d;
    logic signed [SCORE_W-1:0]  best, best_d;
    logic [CLS_W-1:0]           best_idx, best_idx_d;
    logic                       pix_ready_d, core_req_d, pred_valid_d, busy_d;
    logic [NPIX-1:0]            core_img_d;
    logic [CLS_W-1:0]           core_cls_d;
    logic [N_OUT-1:0]           pred_d;
    logic                       accept, ack_hit, take;

    assign accept  = pix_valid && pix_ready && (state == S_LOAD);
    assign ack_hit = core_ack && core_req && (state == S_REQ);
    // class 0 always seeds the running best; strict > keeps the lower index on ties
    assign take    = (core_cls == '0) || ($signed(core_score) > best);

    // next-state and next-output computation; every output is registered below
    always_comb begin
        state_d      = state;
        pix_cnt_d    = pix_cnt;
        best_d       = best;
        best_idx_d   = best_idx;
        pix_ready_d  = pix_ready;
        core_req_d   = core_req;
        core_img_d   = core_img;
        core_cls_d   = core_cls;
        pred_d       = pred;
        pred_valid_d = 1'b0;
        case (state)
            S_IDLE: begin
                state_d     = S_LOAD;
                pix_ready_d = 1'b1;
            end
            S_LOAD: begin
                if (accept) begin
                    core_img_d[pix_cnt] = (pix >= THR8);
                    if (pix_cnt == LAST_PIX) begin
                        pix_cnt_d   = '0;
                        pix_ready_d = 1'b0;
                        core_req_d  = 1'b1;
                        core_cls_d  = '0;
                        state_d     = S_REQ;
                    end else begin
                        pix_cnt_d = pix_cnt + CNT_W'(1);
                    end
                end
            end
            S_REQ: begin
                if (ack_hit) begin
                    if (take) begin
                        best_d     = $signed(core_score);
                        best_idx_d = core_cls;
                    end
                    core_req_d = 1'b0;
                    if (core_cls == LAST_CLS) begin
                        state_d      = S_DONE;
                        pred_valid_d = 1'b1;
                        for (int i = 0; i < N_OUT; i++) begin
                            pred_d[i] = (best_idx_d == CLS_W'(i));
                        end
                    end else begin
                        core_cls_d = core_cls + CLS_W'(1);
                        state_d    = S_GAP;
                    end
                end
            end
            S_GAP: begin
                core_req_d = 1'b1;
                state_d    = S_REQ;
            end
            S_DONE: begin
                pix_ready_d = 1'b1;
                state_d     = S_LOAD;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_REQ) || (state_d == S_GAP) || (state_d == S_DONE);
    end

    // state and output registers, cleared asynchronously by xrst
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state      <= S_IDLE;
            pix_cnt    <= '0;
            best       <= '0;
            best_idx   <= '0;
            pix_ready  <= 1'b0;
            core_req   <= 1'b0;
            core_img   <= '0;
            core_cls   <= '0;
            pred       <= '0;
            pred_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            pix_cnt    <= pix_cnt_d;
            best       <= best_d;
            best_idx   <= best_idx_d;
            pix_ready  <= pix_ready_d;
            core_req   <= core_req_d;
            core_img   <= core_img_d;
            core_cls   <= core_cls_d;
            pred       <= pred_d;
            pred_valid <= pred_valid_d;
            busy       <= busy_d;
        end
    end

endmodule
